// File: rtl/ll_pdu_receiver_pkg.sv
// ll_pdu_receiver_pkg
// Shared types and constants for the BLE link-layer PDU receive path.
//   ble_rx_state_t   : receiver FSM states (encoding is visible on fsm_state)
//   BLE_CRC24_POLY   : CRC-24 tap mask, x^24 implicit
//   BLE_PDU_HDR_BITS : PDU header length in bits
//   keep_mask()      : byte-valid mask from the index of the last byte in a word
package ll_pdu_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        CRC     = 3'd3,
        DONE    = 3'd4
    } ble_rx_state_t;

    localparam logic [23:0] BLE_CRC24_POLY   = 24'h00065B;
    localparam int unsigned BLE_PDU_HDR_BITS = 16;

    function automatic logic [3:0] keep_mask(input logic [1:0] last_byte);
        logic [3:0] m;
        case (last_byte)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ll_pdu_receiver_crc24_lfsr.sv
// crc24_lfsr
// Bit-serial CRC-24 generator, shared by the TX and RX PDU chains.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (register cleared)
//   i_load : load i_seed (priority over i_step)
//   i_seed : LFSR seed
//   i_step : advance one bit using i_bit
//   i_bit  : data bit
//   o_crc  : current LFSR contents
module crc24_lfsr
    import ll_pdu_receiver_pkg::*;
#(
    parameter logic [23:0] POLY = BLE_CRC24_POLY
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [23:0] i_seed,
    input  logic        i_step,
    input  logic        i_bit,
    output logic [23:0] o_crc
);

    logic [23:0] r_crc;
    logic        w_fb;

    assign w_fb  = i_bit ^ r_crc[23];
    assign o_crc = r_crc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_crc <= '0;
        end else if (i_load) begin
            r_crc <= i_seed;
        end else if (i_step) begin
            r_crc <= {r_crc[22:0], 1'b0} ^ (w_fb ? POLY : 24'h000000);
        end
    end

endmodule

// File: rtl/ll_pdu_receiver.sv
// ll_pdu_receiver
// Receives the serial LSB-first bit stream following an access address,
// parses the 16-bit PDU header, packs the payload into 32-bit little-endian
// words and checks the CRC-24.
// Build option: define LL_RX_DEWHITEN_EN to de-whiten the incoming stream
// with a channel-seeded 7-bit LFSR (adds input whitening_enabled).
// Ports:
//   aclk, areset           : clock, synchronous active-high reset
//   restart                : arm for a new packet (aborts any packet in flight)
//   channel, crc_init      : whitening seed / CRC seed, sampled on restart
//   input_tdata/tvalid/tready            : serial bit input
//   header, event_header   : parsed header and its one-cycle strobe
//   payload_tdata/tkeep/tvalid/tready/tlast : packed payload stream
//   event_end, crc_ok, len_err : packet completion strobe and status
//   fsm_state              : current FSM state for debug
module ll_pdu_receiver
    import ll_pdu_receiver_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_LEN = 255,
    parameter logic [23:0] CRC_POLY        = BLE_CRC24_POLY
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        restart,
    input  logic [5:0]  channel,
    input  logic [23:0] crc_init,
`ifdef LL_RX_DEWHITEN_EN
    input  logic        whitening_enabled,
`endif
    input  logic        input_tdata,
    input  logic        input_tvalid,
    output logic        input_tready,
    output logic [15:0] header,
    output logic        event_header,
    output logic [31:0] payload_tdata,
    output logic [3:0]  payload_tkeep,
    output logic        payload_tvalid,
    input  logic        payload_tready,
    output logic        payload_tlast,
    output logic        event_end,
    output logic        crc_ok,
    output logic        len_err,
    output logic [2:0]  fsm_state
);

    ble_rx_state_t r_state, w_state_nxt;
    logic [10:0] r_bitcnt;
    logic [7:0]  r_len;
    logic [15:0] r_hdr_sr, r_header, w_hdr_nxt;
    logic [31:0] r_fill, r_out_data, w_fill_nxt;
    logic [3:0]  r_fill_keep, r_out_keep, w_keep;
    logic        r_fill_full, r_fill_last, r_out_valid, r_out_last;
    logic        r_match, r_evt_hdr, r_evt_end, r_crc_ok, r_len_err;
    logic [23:0] w_crc;
    logic [4:0]  w_crc_idx;
    logic        w_acc, w_bit, w_ready, w_hdr_done, w_len_abort, w_pay_last;
    logic        w_word_done, w_crc_last, w_out_free, w_pending, w_match_nxt;
    logic        w_evt_end;

`ifdef LL_RX_DEWHITEN_EN
    // r_wh[i] holds LFSR position i; position 6 is the whitening output.
    logic [6:0] r_wh;
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wh <= '0;
        end else if (restart) begin
            r_wh <= {channel[0], channel[1], channel[2], channel[3],
                     channel[4], channel[5], 1'b1};
        end else if (w_acc) begin
            r_wh <= {r_wh[5:4], r_wh[3] ^ r_wh[6], r_wh[2:0], r_wh[6]};
        end
    end
    assign w_bit = input_tdata ^ (whitening_enabled & r_wh[6]);
`else
    logic w_unused_channel;
    assign w_unused_channel = ^channel;
    assign w_bit = input_tdata;
`endif

    // PAYLOAD keeps accepting while one word waits downstream; it only
    // stalls once a second completed word is parked in the fill register.
    assign w_ready     = (r_state == HEADER) || (r_state == CRC) ||
                         ((r_state == PAYLOAD) && !r_fill_full);
    assign w_acc       = input_tvalid && w_ready && !restart;
    assign w_hdr_nxt   = {w_bit, r_hdr_sr[15:1]};
    assign w_hdr_done  = w_acc && (r_state == HEADER) &&
                         (r_bitcnt == 11'(BLE_PDU_HDR_BITS - 1));
    assign w_len_abort = 32'(w_hdr_nxt[15:8]) > MAX_PAYLOAD_LEN;
    assign w_pay_last  = (r_bitcnt == ({r_len, 3'b000} - 11'd1));
    assign w_word_done = w_acc && (r_state == PAYLOAD) &&
                         ((r_bitcnt[4:0] == 5'd31) || w_pay_last);
    assign w_keep      = keep_mask(r_bitcnt[4:3]);
    assign w_crc_idx   = 5'd23 - r_bitcnt[4:0];
    assign w_crc_last  = w_acc && (r_state == CRC) && (r_bitcnt[4:0] == 5'd23);
    assign w_out_free  = !r_out_valid || payload_tready;
    // A word is still outstanding after this edge.
    assign w_pending   = r_fill_full || (r_out_valid && !payload_tready);
    assign w_match_nxt = r_match &&
                         !(w_acc && (r_state == CRC) && (w_bit != w_crc[w_crc_idx]));

    always_comb begin
        w_fill_nxt = r_fill;
        w_fill_nxt[r_bitcnt[4:0]] = w_bit;
    end

    crc24_lfsr #(.POLY(CRC_POLY)) u_crc (
        .i_clk  (aclk),
        .i_rst  (areset),
        .i_load (restart),
        .i_seed (crc_init),
        .i_step (w_acc && ((r_state == HEADER) || (r_state == PAYLOAD))),
        .i_bit  (w_bit),
        .o_crc  (w_crc)
    );

    always_ff @(posedge aclk) begin
        if (areset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_evt_end   = 1'b0;
        case (r_state)
            HEADER: begin
                if (w_hdr_done) begin
                    if (w_len_abort) begin
                        w_state_nxt = IDLE;
                        w_evt_end   = 1'b1;
                    end else if (w_hdr_nxt[15:8] == 8'd0) begin
                        w_state_nxt = CRC;
                    end else begin
                        w_state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (w_word_done && w_pay_last) w_state_nxt = CRC;
            end
            CRC: begin
                if (w_crc_last) begin
                    if (w_pending) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = IDLE;
                        w_evt_end   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!w_pending) begin
                    w_state_nxt = IDLE;
                    w_evt_end   = 1'b1;
                end
            end
            default: ;
        endcase
        if (restart) begin
            w_state_nxt = HEADER;
            w_evt_end   = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset || restart) begin
            r_bitcnt    <= '0;
            r_len       <= '0;
            r_hdr_sr    <= '0;
            r_header    <= '0;
            r_fill      <= '0;
            r_fill_keep <= '0;
            r_fill_last <= 1'b0;
            r_fill_full <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_match     <= 1'b1;
            r_evt_hdr   <= 1'b0;
            r_evt_end   <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_evt_hdr <= w_hdr_done;
            r_evt_end <= w_evt_end;
            r_match   <= w_match_nxt;

            if (w_state_nxt != r_state) r_bitcnt <= '0;
            else if (w_acc)             r_bitcnt <= r_bitcnt + 11'd1;

            if (w_acc && (r_state == HEADER)) r_hdr_sr <= w_hdr_nxt;
            if (w_hdr_done) begin
                r_header <= w_hdr_nxt;
                r_len    <= w_hdr_nxt[15:8];
            end

            if (w_evt_end) begin
                r_len_err <= (r_state == HEADER);
                r_crc_ok  <= (r_state != HEADER) && w_match_nxt;
            end

            // A completed word goes straight to the output register when it
            // is free (or draining this cycle); otherwise it parks in r_fill.
            if (w_word_done) begin
                if (w_out_free) begin
                    r_out_data  <= w_fill_nxt;
                    r_out_keep  <= w_keep;
                    r_out_last  <= w_pay_last;
                    r_out_valid <= 1'b1;
                    r_fill      <= '0;
                end else begin
                    r_fill      <= w_fill_nxt;
                    r_fill_keep <= w_keep;
                    r_fill_last <= w_pay_last;
                    r_fill_full <= 1'b1;
                end
            end else begin
                if (w_acc && (r_state == PAYLOAD)) r_fill <= w_fill_nxt;
                if (r_fill_full && w_out_free) begin
                    r_out_data  <= r_fill;
                    r_out_keep  <= r_fill_keep;
                    r_out_last  <= r_fill_last;
                    r_out_valid <= 1'b1;
                    r_fill      <= '0;
                    r_fill_full <= 1'b0;
                end else if (r_out_valid && payload_tready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign input_tready   = w_ready;
    assign header         = r_header;
    assign event_header   = r_evt_hdr;
    assign payload_tdata  = r_out_data;
    assign payload_tkeep  = r_out_keep;
    assign payload_tvalid = r_out_valid;
    assign payload_tlast  = r_out_last;
    assign event_end      = r_evt_end;
    assign crc_ok         = r_crc_ok;
    assign len_err        = r_len_err;
    assign fsm_state      = r_state;

endmodule
